// File: rtl/ps2_host_tx_if.sv
// Command handshake between a PS/2 command source and ps2_host_tx.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_start;
  logic       tx_busy;
  logic       tx_done;
  logic       tx_err;

  modport master (output tx_data, output tx_start,
                  input tx_busy, input tx_done, input tx_err);
  modport slave  (input tx_data, input tx_start,
                  output tx_busy, output tx_done, output tx_err);
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device command transmitter.
// Request-to-send, then shifts data/parity/stop on device clock falls and
// checks the device ACK. Optional feature macro: PS2_TX_RETRY_EN (up to two
// automatic retries of the latched byte before tx_err is reported).
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int FILTER_LEN     = 8
) (
  input  logic         clk,
  input  logic         rst,
  ps2_host_tx_if.slave bus,
  inout  wire          PS2_CLK,
  inout  wire          PS2_DATA
);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int FW      = $clog2(FILTER_LEN + 1);

  localparam logic [CW-1:0] CNT_ZERO = CW'(0);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] INH_LAST = CW'(INHIBIT_CYCLES - 1);
  localparam logic [CW-1:0] INH_DATA = CW'(INHIBIT_CYCLES - 2);
  localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [FW-1:0] FLT_ONE  = FW'(1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INHIBIT = 3'd1;
  localparam logic [2:0] S_RELEASE = 3'd2;
  localparam logic [2:0] S_SEND    = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;
  localparam logic [2:0] S_WAIT    = 3'd5;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q, fall_q;
  logic [FW-1:0] flt_cnt_q;
  logic          clk_s, data_s, timeout_s, fail_s;

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [9:0]    frame_q, frame_d;
  logic          ack_ok_q, ack_ok_d;
  logic          clk_oe_q, clk_oe_d;
  logic          data_oe_q, data_oe_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
`ifdef PS2_TX_RETRY_EN
  logic [1:0]    retry_q, retry_d;
`endif

  assign clk_s  = clk_sync_q[1];
  assign data_s = data_sync_q[1];

  // Bring both open-drain lines into the clk domain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], PS2_CLK};
      data_sync_q <= {data_sync_q[0], PS2_DATA};
    end
  end

  // Glitch filter on the device clock; fall_q strobes on an accepted 1->0 change.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      filt_q    <= 1'b1;
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
    end else if (clk_s == filt_q) begin
      flt_cnt_q <= '0;
      fall_q    <= 1'b0;
    end else if (flt_cnt_q == FLT_LAST) begin
      filt_q    <= clk_s;
      flt_cnt_q <= '0;
      fall_q    <= filt_q;
    end else begin
      flt_cnt_q <= flt_cnt_q + FLT_ONE;
      fall_q    <= 1'b0;
    end
  end

  // Line inactivity watchdog once the device owns the clock.
  assign timeout_s = ((state_q == S_RELEASE) || (state_q == S_SEND) ||
                      (state_q == S_ACK) || (state_q == S_WAIT)) && (cnt_q == TO_LAST);

  // Transfer sequencer next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    frame_d   = frame_q;
    ack_ok_d  = ack_ok_q;
    clk_oe_d  = clk_oe_q;
    data_oe_d = data_oe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    fail_s    = 1'b0;
`ifdef PS2_TX_RETRY_EN
    retry_d   = retry_q;
`endif
    case (state_q)
      S_IDLE: begin
`ifdef PS2_TX_RETRY_EN
        retry_d = 2'd0;
`endif
        if (bus.tx_start) begin
          frame_d   = {1'b1, ~^bus.tx_data, bus.tx_data};
          state_d   = S_INHIBIT;
          cnt_d     = CNT_ZERO;
          clk_oe_d  = 1'b1;
          data_oe_d = 1'b0;
          busy_d    = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_INHIBIT: begin
        if (cnt_q == INH_LAST) begin
          // Start bit stays driven while the clock is handed to the device.
          state_d   = S_RELEASE;
          clk_oe_d  = 1'b0;
          data_oe_d = 1'b1;
          cnt_d     = CNT_ZERO;
        end else begin
          cnt_d     = cnt_q + CNT_ONE;
          data_oe_d = (cnt_q == INH_DATA);
        end
      end
      S_RELEASE: begin
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b1;
        idx_d     = 4'd0;
        cnt_d     = cnt_q + CNT_ONE;
        state_d   = S_SEND;
      end
      S_SEND: begin
        if (fall_q) begin
          cnt_d     = CNT_ZERO;
          data_oe_d = ~frame_q[idx_q];
          idx_d     = idx_q + 4'd1;
          state_d   = (idx_q == 4'd9) ? S_ACK : S_SEND;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_ACK: begin
        if (fall_q) begin
          ack_ok_d = ~data_s;
          cnt_d    = CNT_ZERO;
          state_d  = S_WAIT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q + CNT_ONE;
        if (filt_q && data_s) begin
          if (ack_ok_q) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = S_IDLE;
          end else begin
            fail_s = 1'b1;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      default: begin
        state_d   = S_IDLE;
        clk_oe_d  = 1'b0;
        data_oe_d = 1'b0;
        busy_d    = 1'b0;
      end
    endcase

    // Missing ACK or timeout: release the lines, then retry or report.
    if (fail_s || timeout_s) begin
      done_d    = 1'b0;
      clk_oe_d  = 1'b0;
      data_oe_d = 1'b0;
      cnt_d     = CNT_ZERO;
      idx_d     = 4'd0;
`ifdef PS2_TX_RETRY_EN
      if (retry_q != 2'd2) begin
        retry_d  = retry_q + 2'd1;
        state_d  = S_INHIBIT;
        clk_oe_d = 1'b1;
        busy_d   = 1'b1;
      end else begin
        retry_d = 2'd0;
        state_d = S_IDLE;
        busy_d  = 1'b0;
        err_d   = 1'b1;
      end
`else
      state_d = S_IDLE;
      busy_d  = 1'b0;
      err_d   = 1'b1;
`endif
    end else begin
      err_d = 1'b0;
    end
  end

  // Sequencer state, line drivers and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= CNT_ZERO;
      idx_q     <= 4'd0;
      frame_q   <= 10'd0;
      ack_ok_q  <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= 2'd0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      frame_q   <= frame_d;
      ack_ok_q  <= ack_ok_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
`ifdef PS2_TX_RETRY_EN
      retry_q   <= retry_d;
`endif
    end
  end

  assign PS2_CLK     = clk_oe_q  ? 1'b0 : 1'bz;
  assign PS2_DATA    = data_oe_q ? 1'b0 : 1'bz;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = done_q;
  assign bus.tx_err  = err_q;
endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a behavioural PS/2 device model.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 200;
  localparam int TO   = 5000;
  localparam int FLT  = 8;
  localparam int HALF = 200;
`ifdef PS2_TX_RETRY_EN
  localparam int TRIES = 3;
`else
  localparam int TRIES = 1;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dev_clk_low  = 1'b0;
  logic dev_data_low = 1'b0;
  wire  ps2_clk, ps2_data;
  int   n_checks = 0, n_fails = 0;
  int   done_cnt = 0, err_cnt = 0, both_cnt = 0;

  ps2_host_tx_if bus ();

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FLT)) dut (
    .clk(clk), .rst(rst), .bus(bus), .PS2_CLK(ps2_clk), .PS2_DATA(ps2_data)
  );

  always #5 clk = ~clk;

  // Pulse counters for done/err and their exclusivity.
  always @(negedge clk) begin
    if (bus.tx_done) done_cnt <= done_cnt + 1;
    if (bus.tx_err)  err_cnt  <= err_cnt + 1;
    if (bus.tx_done && bus.tx_err) both_cnt <= both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Frame as the device should see it: data LSB first, odd parity, stop.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    int  ones;
    logic par;
    ones = $countones(b);
    par  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic start_cmd(input logic [7:0] b);
    chk("idle_before", bus.tx_busy, 1'b0);
    bus.tx_data  = b;
    bus.tx_start = 1'b1;
    @(negedge clk);
    bus.tx_start = 1'b0;
    chk("clk_low_lat", ps2_clk === 1'b0, 1'b1);
    chk("busy_high", bus.tx_busy, 1'b1);
  endtask

  // Device side of one attempt: time the inhibit, clock 10 bits, then ACK clock.
  task automatic dev_xfer(input bit ack, input int abort_bit,
                          output logic [9:0] bits, output bit aborted);
    int n;
    bits = 10'd0;
    aborted = 1'b0;
    n = 0;
    while (ps2_clk !== 1'b0 && n < 1000) begin @(negedge clk); n++; end
    n = 0;
    while (ps2_clk === 1'b0 && n < 1000) begin n++; @(negedge clk); end
    chk("inhibit_len", n, INH);
    chk("start_bit", ps2_data, 1'b0);
    repeat (HALF) @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (k == abort_bit) begin
        aborted = 1'b1;
        break;
      end
      repeat (5) @(negedge clk);
      bits[k] = ps2_data;
      repeat (HALF - 5) @(negedge clk);
    end
    if (!aborted) begin
      if (ack) dev_data_low = 1'b1;
      repeat (20) @(negedge clk);
      dev_clk_low = 1'b1;
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      if (ack) begin
        repeat (20) @(negedge clk);
        dev_data_low = 1'b0;
      end
    end
  endtask

  task automatic run_xfer(input logic [7:0] b, input bit ack, input bit overlap);
    int d0, e0, tries, n;
    logic [9:0] bits;
    bit ab;
    d0 = done_cnt;
    e0 = err_cnt;
    tries = ack ? 1 : TRIES;
    start_cmd(b);
    fork
      begin
        for (int a = 0; a < tries; a++) begin
          dev_xfer(ack, -1, bits, ab);
          chk("frame_bits", 32'(bits), 32'(exp_frame(b)));
        end
      end
      begin
        if (overlap) begin
          repeat (1500) @(negedge clk);
          bus.tx_data  = 8'h00;
          bus.tx_start = 1'b1;
          @(negedge clk);
          bus.tx_start = 1'b0;
        end
      end
    join
    n = 0;
    while (!(bus.tx_done || bus.tx_err) && n < 2000) begin @(negedge clk); n++; end
    chk("pulse_seen", n < 2000, 1'b1);
    @(negedge clk);
    chk("done_pulses", done_cnt - d0, ack ? 1 : 0);
    chk("err_pulses", err_cnt - e0, ack ? 0 : 1);
    chk("busy_after", bus.tx_busy, 1'b0);
  endtask

  task automatic run_timeout();
    int d0, e0, n;
    d0 = done_cnt;
    e0 = err_cnt;
    start_cmd(8'h5A);
    for (int a = 0; a < TRIES; a++) begin
      n = 0;
      while (ps2_clk === 1'b0 && n < 1000) begin @(negedge clk); n++; end
      chk("to_inhibit_len", n, INH);
      n = 0;
      while (!bus.tx_err && ps2_clk !== 1'b0 && n < 6000) begin @(negedge clk); n++; end
      chk("timeout_len", n, TO);
    end
    chk("timeout_err", bus.tx_err, 1'b1);
    @(negedge clk);
    chk("to_clk_released", ps2_clk, 1'b1);
    chk("to_data_released", ps2_data, 1'b1);
    chk("to_busy", bus.tx_busy, 1'b0);
    chk("to_done_pulses", done_cnt - d0, 0);
    chk("to_err_pulses", err_cnt - e0, 1);
  endtask

  initial begin
    logic [9:0] bits;
    bit ab;
    bus.tx_data  = 8'h00;
    bus.tx_start = 1'b0;
    #1500000;
    $display("FAIL watchdog got=hang exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9:0] bits;
    bit ab;
    repeat (3) @(negedge clk);
    chk("rst_busy", bus.tx_busy, 1'b0);
    chk("rst_done", bus.tx_done, 1'b0);
    chk("rst_err", bus.tx_err, 1'b0);
    chk("rst_clk_line", ps2_clk, 1'b1);
    chk("rst_data_line", ps2_data, 1'b1);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    run_xfer(8'hED, 1'b1, 1'b0);
    run_xfer(8'hF4, 1'b1, 1'b0);
    run_xfer(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      run_xfer(8'($urandom), $urandom_range(3) != 0, 1'b0);
      repeat ($urandom_range(30, 5)) @(negedge clk);
    end
    run_timeout();
    repeat (10) @(negedge clk);
    run_xfer(8'hFF, 1'b1, 1'b1);
    repeat (10) @(negedge clk);

    start_cmd(8'hED);
    dev_xfer(1'b1, 4, bits, ab);
    chk("abort_reached", ab, 1'b1);
    chk("bit4_driven", ps2_data, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_clk", ps2_clk, 1'b1);
    chk("mid_rst_data", ps2_data, 1'b1);
    chk("mid_rst_busy", bus.tx_busy, 1'b0);
    chk("mid_rst_done", bus.tx_done, 1'b0);
    chk("mid_rst_err", bus.tx_err, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    run_xfer(8'hED, 1'b1, 1'b0);

    chk("done_err_exclusive", both_cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end
endmodule
